// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared register-file write types and widths
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } reg_wr_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback, UART and register-file write signal bundle
interface regfile_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  import regfile_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_stall;

  logic                  uart_valid;
  logic [REG_ADDR_W-1:0] uart_rd;
  logic [DATA_W-1:0]     uart_data;
  logic                  uart_ready;

  logic                  RegWrite;
  logic                  UART_write_enable;
  logic [REG_ADDR_W-1:0] rw;
  logic [DATA_W-1:0]     write_data;
  logic [CNT_W-1:0]      fifo_count;

  // Request side: writeback stage and UART loader.
  modport master (
    output wb_valid, wb_rd, wb_data, uart_valid, uart_rd, uart_data,
    input  wb_stall, uart_ready, RegWrite, UART_write_enable, rw, write_data, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  wb_valid, wb_rd, wb_data, uart_valid, uart_rd, uart_data,
    output wb_stall, uart_ready, RegWrite, UART_write_enable, rw, write_data, fifo_count
  );

endinterface

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// rtl/regfile_write_arbiter_sync_fifo.sv - power-of-two synchronous FIFO for buffered UART writes
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = regfile_pkg::reg_wr_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  T                       din_i,
  input  logic                   pop_i,
  output T                       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter between writeback and UART loader
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int             SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

  reg_wr_t               fifo_head, uart_req, grant_req;
  logic                  fifo_full, fifo_empty;
  logic                  push, ue, starved, grant_wb, grant_uart;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  reg_we_q, reg_we_d, uart_we_q, uart_we_d;
  logic [REG_ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  assign uart_req = '{rd: bus.uart_rd, data: bus.uart_data};
  assign bus.uart_ready = reset & ~fifo_full;
  assign push = bus.uart_valid & bus.uart_ready;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (reg_wr_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (uart_req),
    .pop_i   (grant_uart),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (bus.fifo_count)
  );

  // Writeback wins unless a waiting UART entry has used up its patience.
  assign ue         = ~fifo_empty;
  assign starved    = ue & (starve_q == STARVE_MAX);
  assign grant_wb   = bus.wb_valid & ~starved;
  assign grant_uart = ue & (~bus.wb_valid | starved);
  assign bus.wb_stall = reset & bus.wb_valid & ~grant_wb;
  assign grant_req  = grant_uart ? fifo_head : '{rd: bus.wb_rd, data: bus.wb_data};

  // Starvation counter and output-stage next state; r0 writes are consumed silently.
  always_comb begin
    starve_d  = starve_q;
    reg_we_d  = 1'b0;
    uart_we_d = 1'b0;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    if (!ue || grant_uart) begin
      starve_d = '0;
    end else if (grant_wb && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
    if ((grant_wb || grant_uart) && grant_req.rd != '0) begin
      reg_we_d  = 1'b1;
      uart_we_d = grant_uart;
      rw_d      = grant_req.rd;
      wdata_d   = grant_req.data;
    end
  end

  // State register; reset drops any in-flight write on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q  <= '0;
      reg_we_q  <= 1'b0;
      uart_we_q <= 1'b0;
      rw_q      <= '0;
      wdata_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      reg_we_q  <= reg_we_d;
      uart_we_q <= uart_we_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.RegWrite          = reg_we_q;
  assign bus.UART_write_enable = uart_we_q;
  assign bus.rw                = rw_q;
  assign bus.write_data        = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        uen;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];
  exp_t uart_hold[$];
  exp_t mon_e;

  regfile_write_arbiter_if #(.FIFO_DEPTH(4)) bus();

  regfile_write_arbiter #(
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data, input logic uen);
    exp_t e;
    e.rd = rd; e.data = data; e.uen = uen;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.RegWrite === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rw=%0d data=%h uen=%b expected no write",
                 bus.rw, bus.write_data, bus.UART_write_enable);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.rw, bus.write_data, bus.UART_write_enable} !== {mon_e.rd, mon_e.data, mon_e.uen}) begin
          n_fail++;
          $display("FAIL write: got rw=%0d data=%h uen=%b expected rw=%0d data=%h uen=%b",
                   bus.rw, bus.write_data, bus.UART_write_enable, mon_e.rd, mon_e.data, mon_e.uen);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
    bus.uart_valid = 1'b1; bus.uart_rd = 5'd7; bus.uart_data = 32'h77;

    // Reset held three cycles with both requesters active.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_uart_ready", bus.uart_ready, 0);
      chk("rst_regwrite", bus.RegWrite, 0);
      chk("rst_uen", bus.UART_write_enable, 0);
      chk("rst_rw", bus.rw, 0);
      chk("rst_wdata", bus.write_data, 0);
      chk("rst_count", bus.fifo_count, 0);
      chk("rst_wb_stall", bus.wb_stall, 0);
    end
    reset = 1'b1;
    bus.wb_valid = 1'b0;
    bus.uart_valid = 1'b0;
    cyc();

    // Pipeline-only write.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h10101010;
    #1 chk("pipe_stall", bus.wb_stall, 0);
    expect_wr(5'd1, 32'h10101010, 1'b0);
    cyc();
    bus.wb_valid = 1'b0;

    // UART-only write: two-edge latency.
    bus.uart_valid = 1'b1; bus.uart_rd = 5'd2; bus.uart_data = 32'hDEADBEEF;
    #1 chk("uart_ready", bus.uart_ready, 1);
    expect_wr(5'd2, 32'hDEADBEEF, 1'b1);
    cyc();
    bus.uart_valid = 1'b0;
    chk("uart_count1", bus.fifo_count, 1);
    chk("uart_not_yet", bus.RegWrite, 0);
    cyc();
    chk("uart_count0", bus.fifo_count, 0);
    chk("uart_uen", bus.UART_write_enable, 1);
    cyc();

    // Starvation: one UART entry against continuous writeback.
    for (int i = 0; i <= 10; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_rd = 5'd5;
      bus.wb_data = 32'h100 + ((i == 10) ? 9 : i);
      bus.uart_valid = (i == 0);
      bus.uart_rd = 5'd4;
      bus.uart_data = 32'hCAFEF00D;
      #1;
      if (i == 9) begin
        chk("starve_stall", bus.wb_stall, 1);
        chk("starve_count", bus.fifo_count, 1);
        expect_wr(5'd4, 32'hCAFEF00D, 1'b1);
      end else begin
        chk($sformatf("starve_nostall_%0d", i), bus.wb_stall, 0);
        expect_wr(5'd5, 32'h100 + ((i == 10) ? 9 : i), 1'b0);
      end
      cyc();
    end
    bus.wb_valid = 1'b0;
    bus.uart_valid = 1'b0;
    chk("starve_drained", bus.fifo_count, 0);
    cyc();

    // Full FIFO: five pushes while writeback keeps the port busy.
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h200 + k;
      bus.uart_valid = 1'b1; bus.uart_rd = 5'd8 + 5'(k); bus.uart_data = 32'hA0 + k;
      #1;
      chk($sformatf("full_count_%0d", k), bus.fifo_count, k);
      chk($sformatf("full_ready_%0d", k), bus.uart_ready, (k < 4) ? 1 : 0);
      chk($sformatf("full_stall_%0d", k), bus.wb_stall, 0);
      expect_wr(5'd6, 32'h200 + k, 1'b0);
      if (k < 4) begin
        e.rd = 5'd8 + 5'(k); e.data = 32'hA0 + k; e.uen = 1'b1;
        uart_hold.push_back(e);
      end
      cyc();
    end
    chk("full_never5", bus.fifo_count, 4);
    bus.wb_valid = 1'b0;
    bus.uart_valid = 1'b0;
    while (uart_hold.size() > 0) exp_q.push_back(uart_hold.pop_front());
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk($sformatf("drain_count_%0d", j), bus.fifo_count, 3 - j);
    end

    // r0 writes from both sources are consumed without a strobe.
    bus.uart_valid = 1'b1; bus.uart_rd = 5'd0; bus.uart_data = 32'hBAD0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hBAD1;
    #1 chk("r0_wb_stall", bus.wb_stall, 0);
    cyc();
    bus.uart_valid = 1'b0;
    bus.wb_valid = 1'b0;
    chk("r0_count1", bus.fifo_count, 1);
    chk("r0_regwrite_a", bus.RegWrite, 0);
    chk("r0_rw_a", bus.rw, 11);
    cyc();
    chk("r0_count0", bus.fifo_count, 0);
    chk("r0_regwrite_b", bus.RegWrite, 0);
    chk("r0_rw_b", bus.rw, 11);
    chk("r0_wdata_b", bus.write_data, 32'hA3);
    cyc();
    chk("r0_regwrite_c", bus.RegWrite, 0);
    cyc();
    cyc();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
